ifm_fetch: RTL

IFM_FETCH -- requirements
Module: ifm_fetch

---
 rtl/ifm_pkg.sv | 23 ++
 rtl/ifm_pos_cnt.sv | 46 ++++
 rtl/ifm_fetch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ifm_pkg.sv
// Shared constants and FSM state type for the IFM fetch path, the 5-tap
// IFM shift buffer and the PE array.
`timescale 1ns/1ps
package ifm_pkg;

    // Convolution kernel width: number of taps in the IFM shift buffer.
    localparam int KERNEL_K = 5;

    // Pixel width of the signed feature-map samples.
    localparam int PIX_W = 8;

    // Width of the row/column position counters (dimensions up to 1023).
    localparam int CNT_W = 10;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifm_pos_cnt.sv
// Raster position tracker for the IFM fetch: column counter that wraps at
// IFM_W-1 into a row counter, plus a flag marking the final pixel.
`timescale 1ns/1ps
module ifm_pos_cnt
    import ifm_pkg::*;
#(
    parameter int IFM_W = 32,
    parameter int IFM_H = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] col,
    output logic             last
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IFM_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IFM_H - 1);

    logic [CNT_W-1:0] row;

    // Step through columns; wrapping the last column moves to the next row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Current position is the final pixel of the feature map.
    always_comb begin
        last = (col == COL_LAST) && (row == ROW_LAST);
    end

endmodule

// File: rtl/ifm_fetch.sv
// IFM fetch sequencer: streams one feature map from IFM memory in raster
// order into the 5-tap shift buffer, with stall-driven issue throttling.
`timescale 1ns/1ps
module ifm_fetch
    import ifm_pkg::*;
#(
    parameter int IFM_W  = 32,
    parameter int IFM_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    stall,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic signed [PIX_W-1:0] mem_rdata,
    output logic signed [PIX_W-1:0] ifm_input,
    output logic                    ifm_read,
    output logic                    row_first,
    output logic                    win_valid,
    output logic                    busy,
    output logic                    done
);

    localparam logic [CNT_W-1:0] WIN_COL = CNT_W'(KERNEL_K - 1);

    fetch_state_t state, state_nxt;

    logic                    accept;
    logic                    issue;
    logic [CNT_W-1:0]        col;
    logic                    last_pix;
    logic [ADDR_W-1:0]       addr;
    logic                    rd_win;
    logic signed [PIX_W-1:0] pix_q;

    ifm_pos_cnt #(
        .IFM_W(IFM_W),
        .IFM_H(IFM_H)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .advance(issue),
        .col    (col),
        .last   (last_pix)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; start only counts in IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy   = 1'b0;
                accept = start;
                if (start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                issue = !stall;
                if (!stall && last_pix) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Running read address: raster order is contiguous, so +1 per issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (accept) begin
            addr <= base_addr;
        end else if (issue) begin
            addr <= addr + 1'b1;
        end
    end

    // Read-return pipeline: tag each issued read with its column attributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifm_read  <= 1'b0;
            row_first <= 1'b0;
            rd_win    <= 1'b0;
            win_valid <= 1'b0;
        end else begin
            ifm_read  <= issue;
            row_first <= issue && (col == '0);
            rd_win    <= issue && (col >= WIN_COL);
            win_valid <= ifm_read && rd_win;
        end
    end

    // Hold the last delivered pixel for cycles without a shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= '0;
        end else if (ifm_read) begin
            pix_q <= mem_rdata;
        end
    end

    // Memory data arrives in the ifm_read cycle, so it is forwarded directly
    // then and replaced by the held copy afterwards.
    always_comb begin
        mem_rd_en = issue;
        mem_addr  = addr;
        ifm_input = ifm_read ? mem_rdata : pix_q;
    end

endmodule
